// File: rtl/dbus_if.sv
// Load/store bus between a requester and a memory-side responder.
// A request channel and a response channel, each with its own valid/ready handshake.
`timescale 1ns/1ps
interface dbus_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dbus_responder.sv
// Data-bus responder: one outstanding load/store at a time, served from an internal
// word array after WAIT_STATES cycles, with a registered response held until accepted.
`timescale 1ns/1ps
module dbus_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic   clk,
    input logic   rst,
    dbus_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     offset;
    logic            fault_in;
    logic [AW-1:0]   idx_in;
    logic [AW-1:0]   idx_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [AW-1:0]   cur_idx;
    logic            cur_we;
    logic            cur_fault;
    logic [31:0]     cur_wdata;
    logic [3:0]      cur_be;
    logic            req_hs;
    logic            rsp_hs;
    logic            commit;
    logic [31:0]     rdata_q;
    logic            err_q;

    // BASE_ADDR is word aligned, so offset[1:0] equals the address alignment bits.
    assign offset   = bus.req_addr - BASE_ADDR;
    assign fault_in = (offset[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
    assign idx_in   = offset[AW+1:2];

    assign req_hs = (state == S_IDLE) && bus.req_valid;
    assign rsp_hs = (state == S_RESP) && bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_hs) begin
                    if (fault_in || (WAIT_STATES == 0)) begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A commit straight out of IDLE uses the live request; otherwise the latched copy.
    always_comb begin
        cur_fault = (state == S_IDLE) && fault_in;
        cur_idx   = (state == S_IDLE) ? idx_in        : idx_q;
        cur_we    = (state == S_IDLE) ? bus.req_we    : we_q;
        cur_wdata = (state == S_IDLE) ? bus.req_wdata : wdata_q;
        cur_be    = (state == S_IDLE) ? bus.req_be    : be_q;
    end

    always_ff @(posedge clk) begin
        if (req_hs) begin
            idx_q   <= idx_in;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                err_q   <= cur_fault;
                rdata_q <= (cur_fault || cur_we) ? 32'd0 : mem[cur_idx];
            end else if (rsp_hs) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
